// File: rtl/dmem_ctrl.sv
// dmem_ctrl: valid/ready data memory with byte/half/word access, load extension and fault reporting.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of aligning them.
module dmem_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AB = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] size_q, size_d;
  logic we_q, we_d, uns_q, uns_d, ready_q, ready_d, valid_q, valid_d, err_q, err_d;
  logic [31:0] mem [DEPTH];
  logic accept, commit, mis, err;
  logic [1:0] lane;
  logic [AB-1:0] idx;
  logic [31:0] sh, ld, wd;
  logic [3:0] be;
  assign accept = req_valid & ready_q;
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);
  always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
    mis  = (size_q == 2'd1 && addr_q[0]) || (size_q == 2'd2 && addr_q[1:0] != 2'd0);
    lane = addr_q[1:0];
`else
    mis  = 1'b0;
    lane = size_q == 2'd1 ? {addr_q[1], 1'b0} : size_q == 2'd2 ? 2'd0 : addr_q[1:0];
`endif
    idx = addr_q[AB+1:2];
    err = mis || (&size_q) || (|addr_q[31:AB+2]);
    sh  = mem[idx] >> {lane, 3'b000};
    ld  = size_q == 2'd0 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
          size_q == 2'd1 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
    be  = size_q == 2'd0 ? 4'b0001 << lane :
          size_q == 2'd1 ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
    wd  = size_q == 2'd0 ? {4{wdata_q[7:0]}} :
          size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
  end
  always_comb begin
    state_d = state_q == IDLE ? (accept ? BUSY : IDLE) :
              state_q == BUSY ? (commit ? RESP : BUSY) : (accept ? BUSY : IDLE);
    cnt_d   = accept ? 4'(LATENCY) : (state_q == BUSY && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    addr_d  = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    size_d  = accept ? req_size : size_q;
    we_d    = accept ? req_we : we_q;
    uns_d   = accept ? req_unsigned : uns_q;
    ready_d = state_d != BUSY;
    valid_d = commit;
    rdata_d = commit ? ((err || we_q) ? 32'd0 : ld) : rdata_q;
    err_d   = commit ? err : err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // reset on the commit edge suppresses the write
  always_ff @(posedge clk) begin
    if (rst_n && commit && we_q && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl (LATENCY=1 main instance, LATENCY=0 throughput instance).
module tb_dmem_ctrl;
  localparam int DEPTH = 64;
  localparam int LAT0  = 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, v0, we0, uns0, rdy0, rv0, err0;
  logic [1:0] size0;
  logic [31:0] addr0, wdata0, rd0;
  logic rst1, v1, we1, uns1, rdy1, rv1, err1;
  logic [1:0] size1;
  logic [31:0] addr1, wdata1, rd1;
  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT0)) u0 (
    .clk(clk), .rst_n(rst0), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_size(size0), .req_unsigned(uns0), .req_addr(addr0), .req_wdata(wdata0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0));
  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(0)) u1 (
    .clk(clk), .rst_n(rst1), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_size(size1), .req_unsigned(uns1), .req_addr(addr1), .req_wdata(wdata1),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1));
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [31:0] d; logic e; int acc;} exp_t;
  exp_t sb[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rv0) begin
      exp_t e;
      if (sb.size() == 0) chk("spurious_rsp", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("rdata", rd0, e.d);
        chk("err", {31'd0, err0}, {31'd0, e.e});
        chk("latency", cyc - e.acc, LAT0 + 2);
      end
    end
  end
  task automatic xfer(logic we, logic [1:0] sz, logic un, logic [31:0] a, logic [31:0] wd,
                      logic [31:0] ed, logic ee);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    v0 = 1'b1; we0 = we; size0 = sz; uns0 = un; addr0 = a; wdata0 = wd;
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, rdy0}, 32'd1);
    e.d = ed; e.e = ee; e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst0 = 0; v0 = 0; we0 = 0; size0 = 0; uns0 = 0; addr0 = 0; wdata0 = 0;
    rst1 = 0; v1 = 0; we1 = 0; size1 = 0; uns1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_valid", {31'd0, rv0}, 32'd0);
    chk("rst_rdata", rd0, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    rst0 = 1; rst1 = 1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, rdy0}, 32'd1);
    xfer(1, 2, 0, 32'h10, 32'h8000_00F0, 32'h0, 0);
    xfer(0, 2, 0, 32'h10, 0, 32'h8000_00F0, 0);
    xfer(0, 0, 0, 32'h10, 0, 32'hFFFF_FFF0, 0);
    xfer(0, 0, 1, 32'h13, 0, 32'h0000_0080, 0);
    xfer(0, 1, 0, 32'h12, 0, 32'hFFFF_8000, 0);
    xfer(0, 1, 1, 32'h12, 0, 32'h0000_8000, 0);
    xfer(1, 2, 0, 32'h20, 32'h1122_3344, 32'h0, 0);
    xfer(1, 0, 0, 32'h21, 32'h0000_00AB, 32'h0, 0);
    xfer(0, 2, 0, 32'h20, 0, 32'h1122_AB44, 0);
    xfer(0, 0, 0, 32'h21, 0, 32'hFFFF_FFAB, 0);
    xfer(1, 2, 0, 32'h0, 32'hCAFE_BABE, 32'h0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    xfer(0, 2, 0, 32'h2, 0, 32'h0, 1);
`else
    xfer(0, 2, 0, 32'h2, 0, 32'hCAFE_BABE, 0);
`endif
    xfer(1, 2, 0, DEPTH * 4, 32'h0000_DEAD, 32'h0, 1);
    xfer(0, 2, 0, 32'h0, 0, 32'hCAFE_BABE, 0);
    xfer(0, 3, 0, 32'h10, 0, 32'h0, 1);
    xfer(1, 1, 0, 32'h22, 32'h0000_5566, 32'h0, 0);
    xfer(0, 2, 0, 32'h20, 0, 32'h5566_AB44, 0);
    drain();
    chk("hold_valid", {31'd0, rv0}, 32'd0);
    chk("hold_rdata", rd0, 32'h5566_AB44);
    @(negedge clk);
    v0 = 1; we0 = 1; size0 = 2; uns0 = 0; addr0 = 32'h10; wdata0 = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    v0 = 0; rst0 = 0;
    @(negedge clk);
    chk("busy_rst_valid", {31'd0, rv0}, 32'd0);
    chk("busy_rst_ready", {31'd0, rdy0}, 32'd0);
    chk("busy_rst_rdata", rd0, 32'd0);
    chk("busy_rst_err", {31'd0, err0}, 32'd0);
    rst0 = 1;
    @(negedge clk);
    chk("busy_rst_ready_rel", {31'd0, rdy0}, 32'd1);
    xfer(0, 2, 0, 32'h10, 0, 32'h8000_00F0, 0);
    drain();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      v1 = 1; size1 = 2; uns1 = 0;
      we1 = i < 3; addr1 = i < 3 ? 32'(4 * i) : 32'h4; wdata1 = 32'hA0 + 32'(i);
      @(posedge clk);
      @(negedge clk);
      chk("tp_busy_valid", {31'd0, rv1}, 32'd0);
      chk("tp_busy_ready", {31'd0, rdy1}, 32'd0);
      @(negedge clk);
      chk("tp_valid", {31'd0, rv1}, 32'd1);
      chk("tp_ready", {31'd0, rdy1}, 32'd1);
      chk("tp_rdata", rd1, i < 3 ? 32'h0 : 32'hA1);
      chk("tp_err", {31'd0, err1}, 32'd0);
    end
    v1 = 0;
    @(negedge clk);
    chk("tp_idle_valid", {31'd0, rv1}, 32'd0);
    chk("tp_idle_ready", {31'd0, rdy1}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
